score_sequencer: RTL
====================

// Module: score_sequencer
// PURPOSE
//  Parametrised music-score player: fetches (key, duration) pairs from a synchronous score RAM,
//  times each note in beats and drives the speaker square wave through an internal tone generator.
//  Adds pause/resume, stop, loop, a tempo select and N score regions to the single-shot player.
//  Sits between the conditioned push-button pulses (debounce and one-shot upstream) and the speaker pin.
// PARAMETERS
//  ADDR_BITS    5           score RAM address width
//  KEY_BITS     4           key code width; key 0 = rest (silent)
//  TIME_BITS    4           duration width in beats; duration 0 = end-of-score marker
//  NUM_SCORES   4           score regions; SEL_BITS = $clog2(NUM_SCORES); region size = 2**ADDR_BITS/NUM_SCORES
//  BEAT_CYCLES  12_500_000  CLK cycles per beat at Tempo=0
//  GAP_CYCLES   250_000     silent articulation gap after every note
// PORTS
//  CLK          in   1          system clock
//  RESET        in   1          synchronous, active-high
//  Play         in   1          1-cycle pulse: (re)start the selected score from its base
//  Stop         in   1          1-cycle pulse: abort, go idle
//  Pause        in   1          1-cycle pulse: toggle pause/resume while playing
//  Loop         in   1          level: restart at end of score instead of finishing
//  Tempo        in   2          beat length = BEAT_CYCLES >> Tempo (3 treated as 2)
//  ScoreSelect  in   SEL_BITS   region to play; sampled only on Play
//  ScoreAddress out  ADDR_BITS  RAM read address
//  ScoreKey     in   KEY_BITS   RAM key data, valid 1 cycle after ScoreAddress
//  ScoreTime    in   TIME_BITS  RAM duration data, same timing as ScoreKey
//  Speaker      out  1          square-wave output
//  Playing      out  1          high in FETCH/WAIT/PLAY/GAP/PAUSED
//  Done         out  1          1-cycle pulse on non-loop end of score
// BEHAVIOUR
//  Reset: state IDLE; Speaker, Playing, Done = 0; ScoreAddress = 0; all counters 0.
//  Base = ScoreSelect << (ADDR_BITS-SEL_BITS); last = base + region size - 1.
//  IDLE   : Play -> latch base, ScoreAddress=base, -> FETCH.
//  FETCH  : one cycle (address presented) -> WAIT.
//  WAIT   : capture ScoreKey/ScoreTime. Time==0 -> END. Else load beat/cycle counters -> PLAY.
//  PLAY   : tone gen runs with captured key (rest: Speaker held 0); counts Time*beat-length cycles
//           exactly, then -> GAP with Speaker forced 0.
//  GAP    : GAP_CYCLES cycles; then if ScoreAddress==last -> END, else ScoreAddress+1 -> FETCH.
//  END    : Loop=1 -> ScoreAddress=base, -> FETCH (no Done). Loop=0 -> Done pulse, -> IDLE.
//  PAUSED : entered from PLAY/GAP on Pause; counters and tone phase frozen, Speaker=0;
//           Pause again returns to the saved state and continues the remaining count.
//  Priority per cycle: RESET > Stop > Play > Pause. Stop in any state -> IDLE, Speaker=0, no Done.
//  Play while Playing: restart from newly sampled region base; no Done for the aborted run.
//  Pause in IDLE/FETCH/WAIT: ignored. Tempo is sampled at note load (WAIT); changes mid-note
//  take effect on the next note. Loop is sampled at END.
//  Note-to-note latency: last PLAY cycle -> GAP_CYCLES -> FETCH -> WAIT -> first PLAY cycle.
//  Duration counter width >= TIME_BITS + $clog2(BEAT_CYCLES+1); no wrap.
//  Tone: half-period counter reloads from key_half_period(key); Speaker toggles on reload;
//  counter and Speaker cleared on each note load so every note starts with Speaker=0.
// STRUCTURE
//  Package score_pkg: state enum (IDLE,FETCH,WAIT,PLAY,GAP,END,PAUSED), key_half_period()
//  table for keys 1..2**KEY_BITS-1, KEY_REST=0, TIME_END=0.
//  Sub-module tone_gen (CLK, RESET, Enable, Clear, HalfPeriod -> Speaker); the sequencer FSM
//  and beat/duration counters live in score_sequencer.
// TESTING (sim: BEAT_CYCLES=8, GAP_CYCLES=2, behavioural RAM, 1-cycle read)
//  1 Region0 = (C,2),(D,1),(0,0); Play -> C for 16 cycles, gap 2, D for 8, Done once, Playing=0.
//  2 Same score, Tempo=1 -> C lasts 8 cycles, D 4; Tempo=3 -> C lasts 4 cycles.
//  3 Loop=1 -> after (D,1) ScoreAddress returns to 0, no Done; drop Loop -> Done at next end.
//  4 Pause 5 cycles into C, hold 20 cycles -> Speaker=0, address fixed; resume -> C plays 11 more.
//  5 ScoreSelect=2, Play -> ScoreAddress starts at 16; Play+Stop same cycle -> IDLE, no Done.
//  6 Region full (8 notes, no marker) -> ends after address 7; RESET mid-note -> all outputs 0.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and tone table for the score sequencer.
package score_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        PLAY,
        GAP,
        END,
        PAUSED
    } state_e;

    localparam int unsigned KEY_REST  = 0;
    localparam int unsigned TIME_END  = 0;
    localparam int unsigned HALF_BITS = 17;

    // Half-period in 50 MHz clock cycles, C4 (key 1) up to C6 (key 15).
    function automatic logic [HALF_BITS-1:0] key_half_period(input int unsigned key);
        logic [HALF_BITS-1:0] hp;
        case (key)
            1:       hp = HALF_BITS'(95556);
            2:       hp = HALF_BITS'(85131);
            3:       hp = HALF_BITS'(75843);
            4:       hp = HALF_BITS'(71586);
            5:       hp = HALF_BITS'(63776);
            6:       hp = HALF_BITS'(56818);
            7:       hp = HALF_BITS'(50619);
            8:       hp = HALF_BITS'(47778);
            9:       hp = HALF_BITS'(42566);
            10:      hp = HALF_BITS'(37921);
            11:      hp = HALF_BITS'(35793);
            12:      hp = HALF_BITS'(31888);
            13:      hp = HALF_BITS'(28409);
            14:      hp = HALF_BITS'(25310);
            15:      hp = HALF_BITS'(23889);
            default: hp = '0;
        endcase
        return hp;
    endfunction

endpackage

// File: rtl/score_sequencer_tone_gen.sv
// Square-wave tone generator; phase and counter hold while Enable is low.
module tone_gen
    import score_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 Enable,
    input  logic                 Clear,
    input  logic [HALF_BITS-1:0] HalfPeriod,
    output logic                 Speaker
);

    logic [HALF_BITS-1:0] cnt_q, cnt_d;
    logic                 phase_q, phase_d;
    logic                 spk_q, spk_d;

    // Output follows the phase only while counting, otherwise silent.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        spk_d   = 1'b0;
        if (Clear) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (Enable) begin
            if (cnt_q == '0) begin
                cnt_d   = HalfPeriod - HALF_BITS'(1);
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q - HALF_BITS'(1);
            end
            spk_d = phase_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            spk_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            spk_q   <= spk_d;
        end
    end

    assign Speaker = spk_q;

endmodule

// File: rtl/score_sequencer.sv
// Score player: walks a RAM region of (key, duration) pairs, times notes in beats
// and drives the speaker through tone_gen; supports pause, stop, loop and tempo.
module score_sequencer
    import score_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 5,
    parameter int unsigned KEY_BITS    = 4,
    parameter int unsigned TIME_BITS   = 4,
    parameter int unsigned NUM_SCORES  = 4,
    parameter int unsigned BEAT_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 250_000,
    parameter int unsigned TONE_SHIFT  = 0,
    localparam int unsigned SEL_BITS   = (NUM_SCORES > 1) ? $clog2(NUM_SCORES) : 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 Play,
    input  logic                 Stop,
    input  logic                 Pause,
    input  logic                 Loop,
    input  logic [1:0]           Tempo,
    input  logic [SEL_BITS-1:0]  ScoreSelect,
    output logic [ADDR_BITS-1:0] ScoreAddress,
    input  logic [KEY_BITS-1:0]  ScoreKey,
    input  logic [TIME_BITS-1:0] ScoreTime,
    output logic                 Speaker,
    output logic                 Playing,
    output logic                 Done
);

    localparam int unsigned REGION    = (2 ** ADDR_BITS) / NUM_SCORES;
    localparam int unsigned REG_SHIFT = ADDR_BITS - SEL_BITS;
    localparam int unsigned BEAT_BITS = $clog2(BEAT_CYCLES + 1);
    localparam int unsigned DUR_BITS  = TIME_BITS + BEAT_BITS;
    localparam int unsigned GAP_BITS  = $clog2(GAP_CYCLES + 1);

    state_e               state_q, state_d;
    state_e               saved_q, saved_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS-1:0] base_q, base_d;
    logic [KEY_BITS-1:0]  key_q, key_d;
    logic [DUR_BITS-1:0]  dur_q, dur_d;
    logic [GAP_BITS-1:0]  gap_q, gap_d;
    logic                 playing_q, playing_d;
    logic                 done_q, done_d;

    logic [1:0]           tempo_sh_c;
    logic [BEAT_BITS-1:0] beat_len_c;
    logic [ADDR_BITS-1:0] sel_base_c;
    logic [ADDR_BITS-1:0] addr_last_c;
    logic [HALF_BITS-1:0] hp_raw_c, hp_c;
    logic                 tone_en_c, tone_clr_c;

    assign tempo_sh_c  = (Tempo == 2'd3) ? 2'd2 : Tempo;
    assign beat_len_c  = BEAT_BITS'(BEAT_CYCLES >> tempo_sh_c);
    assign sel_base_c  = ADDR_BITS'(ScoreSelect) << REG_SHIFT;
    assign addr_last_c = base_q + ADDR_BITS'(REGION - 1);

    // Next state; Stop beats Play, Play beats Pause.
    always_comb begin
        state_d = state_q;
        saved_d = saved_q;
        addr_d  = addr_q;
        base_d  = base_q;
        key_d   = key_q;
        dur_d   = dur_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        if (Stop) begin
            state_d = IDLE;
        end else if (Play) begin
            base_d  = sel_base_c;
            addr_d  = sel_base_c;
            state_d = FETCH;
        end else begin
            case (state_q)
                IDLE:  state_d = IDLE;
                FETCH: state_d = WAIT;
                WAIT: begin
                    key_d = ScoreKey;
                    if (ScoreTime == TIME_BITS'(TIME_END)) begin
                        state_d = END;
                    end else begin
                        dur_d   = DUR_BITS'(ScoreTime) * DUR_BITS'(beat_len_c);
                        state_d = PLAY;
                    end
                end
                PLAY: begin
                    if (Pause) begin
                        saved_d = PLAY;
                        state_d = PAUSED;
                    end else if (dur_q <= DUR_BITS'(1)) begin
                        gap_d   = GAP_BITS'(GAP_CYCLES);
                        state_d = GAP;
                    end else begin
                        dur_d = dur_q - DUR_BITS'(1);
                    end
                end
                GAP: begin
                    if (Pause) begin
                        saved_d = GAP;
                        state_d = PAUSED;
                    end else if (gap_q <= GAP_BITS'(1)) begin
                        if (addr_q == addr_last_c) begin
                            state_d = END;
                        end else begin
                            addr_d  = addr_q + ADDR_BITS'(1);
                            state_d = FETCH;
                        end
                    end else begin
                        gap_d = gap_q - GAP_BITS'(1);
                    end
                end
                END: begin
                    if (Loop) begin
                        addr_d  = base_q;
                        state_d = FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                PAUSED: begin
                    if (Pause) state_d = saved_q;
                end
                default: state_d = IDLE;
            endcase
        end
        playing_d = (state_d == FETCH) || (state_d == WAIT) || (state_d == PLAY) ||
                    (state_d == GAP) || (state_d == PAUSED);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            saved_q   <= IDLE;
            addr_q    <= '0;
            base_q    <= '0;
            key_q     <= '0;
            dur_q     <= '0;
            gap_q     <= '0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            saved_q   <= saved_d;
            addr_q    <= addr_d;
            base_q    <= base_d;
            key_q     <= key_d;
            dur_q     <= dur_d;
            gap_q     <= gap_d;
            playing_q <= playing_d;
            done_q    <= done_d;
        end
    end

    // Tone only advances on PLAY cycles that stay in PLAY, so pause freezes the phase.
    assign hp_raw_c   = key_half_period(32'(key_q)) >> TONE_SHIFT;
    assign hp_c       = (hp_raw_c == '0) ? HALF_BITS'(1) : hp_raw_c;
    assign tone_en_c  = (state_q == PLAY) && (state_d == PLAY) &&
                        (key_q != KEY_BITS'(KEY_REST));
    assign tone_clr_c = (state_q == WAIT);

    tone_gen u_tone (
        .CLK        (CLK),
        .RESET      (RESET),
        .Enable     (tone_en_c),
        .Clear      (tone_clr_c),
        .HalfPeriod (hp_c),
        .Speaker    (Speaker)
    );

    assign ScoreAddress = addr_q;
    assign Playing      = playing_q;
    assign Done         = done_q;

endmodule
